spc_aram_arbiter: RTL and testbench
===================================

Name: spc_aram_arbiter

Overview:
- Time-slot scheduler for the 64 KiB audio RAM (ARAM).
- Shares a single-port synchronous RAM between three requesters:
  - the SPC700 core, which is stalled through its RDY input;
  - the S-DSP voice/echo fetch port;
  - a host upload/debug port.
- Generates the per-microcycle RDY pulse that advances the SPC700. It is therefore also the CPU clock-enable source for the audio subsystem.

Parameters:
- SLOT_CYCLES, 3: CLK cycles per access slot. Minimum 3.
- NSLOTS, 4: slots per round.
- DSP_SLOTS, 1: slot indices 0..DSP_SLOTS-1 are reserved for the DSP. Must satisfy 1 <= DSP_SLOTS < NSLOTS.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- CPU_A  in  16  SPC700 address; stable while CPU_RDY is low.
- CPU_DO  in  8  SPC700 write data.
- CPU_WE_N  in  1  SPC700 write strobe, active-low.
- CPU_DI  out  8  read data to SPC700.
- CPU_RDY  out  1  one-cycle advance pulse to the SPC700.
- DSP_REQ  in  1  DSP access request; level, held until ack.
- DSP_A  in  16  DSP address.
- DSP_WE  in  1  DSP write (echo buffer).
- DSP_DO  in  8  DSP write data.
- DSP_DI  out  8  DSP read data.
- DSP_ACK  out  1  one-cycle completion pulse to DSP.
- HOST_REQ, HOST_A[15:0], HOST_WE, HOST_DO[7:0], HOST_DI[7:0], HOST_ACK: host port, same semantics as the DSP port.
- RAM_A  out  16  RAM address.
- RAM_DO  out  8  RAM write data.
- RAM_WE  out  1  RAM write enable.
- RAM_CE  out  1  RAM access enable.
- RAM_DI  in  8  RAM read data, valid one CLK after RAM_CE.
- SLOT_IDX  out  log2(NSLOTS)  current slot index, for DSP/timer alignment.

Behaviour:
- Counters:
  - cyc counts 0..SLOT_CYCLES-1 and wraps.
  - SLOT_IDX increments when cyc wraps, and itself wraps from NSLOTS-1 to 0.
- Owner decision: the owner is latched at cyc==0 and held for the whole slot.
  - DSP slot (SLOT_IDX < DSP_SLOTS): owner is DSP if DSP_REQ is high, else IDLE. The CPU never uses a DSP slot.
  - CPU slot: owner is HOST if HOST_REQ is high, else CPU. The host has absolute priority; the CPU stalls indefinitely while the host requests. This is intended for upload.
  - A request that arrives mid-slot or in a foreign slot waits for the next eligible slot start.
- Slot cycle 0 (owner != IDLE):
  - RAM_CE=1 and RAM_A = owner address.
  - RAM_WE=1 only for an owner write (CPU_WE_N==0, DSP_WE, or HOST_WE).
  - RAM_DO = owner write data.
- Slot cycle 1: RAM_DI is registered into the owner's DI register (CPU_DI, DSP_DI or HOST_DI) on reads only. The DI registers are not modified on writes.
- Last slot cycle (cyc == SLOT_CYCLES-1): a one-CLK pulse goes to the owner (CPU_RDY, DSP_ACK or HOST_ACK).
  - CPU_DI is therefore stable when the SPC700 samples it with EN=1.
- Outside cycle 0, RAM_CE and RAM_WE are 0. RAM_A and RAM_DO hold their last values.
- At most one of CPU_RDY, DSP_ACK and HOST_ACK is high in any cycle.
- CPU_RDY cadence with no host traffic: exactly one pulse per CPU slot, i.e. (NSLOTS-DSP_SLOTS) pulses per NSLOTS*SLOT_CYCLES CLKs.
- IDLE slot: no RAM access and no pulses.
- Requester dropping REQ mid-slot: the access in progress still completes and its ACK is still issued; the requester must ignore it. No abort.
- Reset: the next cycle after RST is released has cyc=0 and SLOT_IDX=0. While RST is high, all of the following hold:
  - cyc, SLOT_IDX = 0;
  - owner = IDLE;
  - CPU_RDY, DSP_ACK, HOST_ACK, RAM_CE, RAM_WE = 0;
  - RAM_A = 0, RAM_DO = 0;
  - CPU_DI, DSP_DI, HOST_DI = 8'h00.
- Reset mid-slot: the access is dropped, no ack is issued, and any write already issued at cycle 0 stands.

Test Plan:
- CPU-only run, defaults, CPU_A=0xFFC0 read: with RAM_DI=0x5A, the first CPU_RDY pulse comes at CLK 5 after reset (slot 1, cycle 2) with CPU_DI=0x5A. Pulses then repeat on a 12-CLK cycle, three per round, none during slot 0.
- CPU write CPU_A=0x00F4, CPU_DO=0x33, CPU_WE_N=0: a one-cycle RAM_WE with RAM_A=0x00F4 and RAM_DO=0x33 at cyc 0 of a CPU slot. CPU_DI is unchanged.
- DSP_REQ held with DSP_A=0x0200: RAM_CE at cyc 0 of slot 0 only. DSP_ACK comes 2 CLKs later with DSP_DI equal to RAM_DI. With DSP_REQ low, slot 0 produces no RAM_CE.
- HOST_REQ held for 2 rounds: CPU_RDY stays low for 24 CLKs. There are 6 HOST_ACK pulses. DSP slot-0 access is still served. CPU_RDY resumes in the first CPU slot after HOST_REQ drops.
- DSP_REQ and HOST_REQ both asserted at slot 1, cyc 1: the host is served in slot 2 and the DSP in the next slot 0. There is never more than one ack per cycle.
- RST asserted at cyc 1 of a CPU read slot: no CPU_RDY pulse and all outputs at reset values. After release, a RAM access occurs only from slot 1 onward (slot 0 IDLE unless DSP_REQ is high).

Source files
------------

// File: rtl/spc_aram_arbiter.sv
// spc_aram_arbiter: time-slot scheduler sharing the ARAM between SPC700, S-DSP and host
module spc_aram_arbiter #(
  parameter int SLOT_CYCLES = 3,
  parameter int NSLOTS = 4,
  parameter int DSP_SLOTS = 1,
  localparam int CW = $clog2(SLOT_CYCLES),
  localparam int SW = $clog2(NSLOTS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [15:0]   CPU_A,
  input  logic [7:0]    CPU_DO,
  input  logic          CPU_WE_N,
  output logic [7:0]    CPU_DI,
  output logic          CPU_RDY,
  input  logic          DSP_REQ,
  input  logic [15:0]   DSP_A,
  input  logic          DSP_WE,
  input  logic [7:0]    DSP_DO,
  output logic [7:0]    DSP_DI,
  output logic          DSP_ACK,
  input  logic          HOST_REQ,
  input  logic [15:0]   HOST_A,
  input  logic          HOST_WE,
  input  logic [7:0]    HOST_DO,
  output logic [7:0]    HOST_DI,
  output logic          HOST_ACK,
  output logic [15:0]   RAM_A,
  output logic [7:0]    RAM_DO,
  output logic          RAM_WE,
  output logic          RAM_CE,
  input  logic [7:0]    RAM_DI,
  output logic [SW-1:0] SLOT_IDX
);
  typedef enum logic [1:0] {IDLE, CPU, DSP, HOST} owner_t;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NSLOTS - 1);
  localparam logic [SW-1:0] DSP_LIM = SW'(DSP_SLOTS);
  logic [CW-1:0] cyc;
  owner_t owner_q, owner_d;
  logic we_q, wr_sel, start;
  logic [15:0] a_q, addr_sel;
  logic [7:0] do_q, do_sel;
  // Owner candidate for the slot starting now, plus its address/data/direction; the cycle-0 access is driven straight from it
  always_comb begin
    owner_d = RST ? IDLE : (SLOT_IDX < DSP_LIM) ? (DSP_REQ ? DSP : IDLE) : (HOST_REQ ? HOST : CPU);
    addr_sel = owner_d == DSP ? DSP_A : owner_d == HOST ? HOST_A : CPU_A;
    do_sel = owner_d == DSP ? DSP_DO : owner_d == HOST ? HOST_DO : CPU_DO;
    wr_sel = owner_d == DSP ? DSP_WE : owner_d == HOST ? HOST_WE : !CPU_WE_N;
    start = cyc == '0 && owner_d != IDLE;
    RAM_CE = start;
    RAM_WE = start && wr_sel;
    RAM_A = start ? addr_sel : a_q;
    RAM_DO = start ? do_sel : do_q;
    CPU_RDY = cyc == LAST && owner_q == CPU;
    DSP_ACK = cyc == LAST && owner_q == DSP;
    HOST_ACK = cyc == LAST && owner_q == HOST;
  end
  // Slot counters, owner latch at slot start, RAM bus hold registers and read-data capture one cycle after the access
  always_ff @(posedge CLK) begin
    if (RST) begin
      cyc <= '0;
      SLOT_IDX <= '0;
      owner_q <= IDLE;
      we_q <= 1'b0;
      a_q <= '0;
      do_q <= '0;
      CPU_DI <= '0;
      DSP_DI <= '0;
      HOST_DI <= '0;
    end else begin
      cyc <= cyc == LAST ? '0 : cyc + 1'b1;
      if (cyc == LAST) SLOT_IDX <= SLOT_IDX == SLOT_LAST ? '0 : SLOT_IDX + 1'b1;
      if (cyc == '0) begin
        owner_q <= owner_d;
        we_q <= wr_sel;
      end
      if (start) begin
        a_q <= addr_sel;
        do_q <= do_sel;
      end
      if (cyc == CW'(1) && !we_q) begin
        if (owner_q == CPU) CPU_DI <= RAM_DI;
        if (owner_q == DSP) DSP_DI <= RAM_DI;
        if (owner_q == HOST) HOST_DI <= RAM_DI;
      end
    end
  end
endmodule

// File: tb/tb_spc_aram_arbiter.sv
// tb_spc_aram_arbiter: table-driven slot checks plus multi-cycle corner sequences for the ARAM arbiter
module tb_spc_aram_arbiter;
  logic CLK = 1'b0, RST = 1'b1;
  logic [15:0] CPU_A = 16'hFFC0, DSP_A = 16'h0200, HOST_A = 16'h1234;
  logic [7:0] CPU_DO = 8'h33, DSP_DO = 8'h00, HOST_DO = 8'h99;
  logic CPU_WE_N = 1'b1, DSP_REQ = 1'b1, DSP_WE = 1'b0, HOST_REQ = 1'b0, HOST_WE = 1'b0;
  logic [7:0] CPU_DI, DSP_DI, HOST_DI, RAM_DO, RAM_DI = 8'h00;
  logic CPU_RDY, DSP_ACK, HOST_ACK, RAM_WE, RAM_CE;
  logic [15:0] RAM_A;
  logic [1:0] SLOT_IDX;
  int checks = 0, failures = 0;

  spc_aram_arbiter dut (
    .CLK(CLK), .RST(RST),
    .CPU_A(CPU_A), .CPU_DO(CPU_DO), .CPU_WE_N(CPU_WE_N), .CPU_DI(CPU_DI), .CPU_RDY(CPU_RDY),
    .DSP_REQ(DSP_REQ), .DSP_A(DSP_A), .DSP_WE(DSP_WE), .DSP_DO(DSP_DO), .DSP_DI(DSP_DI), .DSP_ACK(DSP_ACK),
    .HOST_REQ(HOST_REQ), .HOST_A(HOST_A), .HOST_WE(HOST_WE), .HOST_DO(HOST_DO), .HOST_DI(HOST_DI), .HOST_ACK(HOST_ACK),
    .RAM_A(RAM_A), .RAM_DO(RAM_DO), .RAM_WE(RAM_WE), .RAM_CE(RAM_CE), .RAM_DI(RAM_DI), .SLOT_IDX(SLOT_IDX)
  );

  always #5 CLK = ~CLK;

  // RAM model: read data valid only in the cycle after the access; writes return a marker that must not be captured
  always @(posedge CLK) RAM_DI <= RAM_CE ? (RAM_WE ? 8'hEE : RAM_A[15:8] ^ RAM_A[7:0] ^ 8'h65) : 8'h00;

  typedef struct {
    logic [15:0] cpu_a;
    logic cpu_we_n, dreq, hreq, hwe;
    logic [1:0] slot;
    logic ce, we;
    logic [15:0] a;
    logic [7:0] dout;
    logic [1:0] pulse;
    logic [7:0] cdi, ddi, hdi;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
    #2;
    chk("one_ack", 32'($countones({CPU_RDY, DSP_ACK, HOST_ACK}) <= 1), 32'd1);
  endtask

  function automatic logic [2:0] pulse_vec(input logic [1:0] p);
    return p == 2'd1 ? 3'b100 : p == 2'd2 ? 3'b010 : p == 2'd3 ? 3'b001 : 3'b000;
  endfunction

  initial begin
    int nr, nd, nh, th, td, tc;
    //          cpu_a      we_n  dreq  hreq  hwe   slot  ce    we    a          dout   pulse cdi    ddi    hdi
    tbl[0]  = '{16'hFFC0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{16'hFFC0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'hFFC0, 8'h00, 2'd1, 8'h5A, 8'h00, 8'h00};
    tbl[2]  = '{16'hFFC0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 16'hFFC0, 8'h00, 2'd1, 8'h5A, 8'h00, 8'h00};
    tbl[3]  = '{16'hFFC0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 16'hFFC0, 8'h00, 2'd1, 8'h5A, 8'h00, 8'h00};
    tbl[4]  = '{16'h00F4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 2'd0, 8'h5A, 8'h00, 8'h00};
    tbl[5]  = '{16'h00F4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 16'h00F4, 8'h33, 2'd1, 8'h5A, 8'h00, 8'h00};
    tbl[6]  = '{16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 16'h1000, 8'h00, 2'd1, 8'h75, 8'h00, 8'h00};
    tbl[7]  = '{16'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 16'h1000, 8'h00, 2'd1, 8'h75, 8'h00, 8'h00};
    tbl[8]  = '{16'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'h0200, 8'h00, 2'd2, 8'h75, 8'h67, 8'h00};
    tbl[9]  = '{16'h1000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 16'h1234, 8'h00, 2'd3, 8'h75, 8'h67, 8'h43};
    tbl[10] = '{16'h1000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 16'h1234, 8'h99, 2'd3, 8'h75, 8'h67, 8'h43};
    tbl[11] = '{16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 16'h1000, 8'h00, 2'd1, 8'h75, 8'h67, 8'h43};
    tbl[12] = '{16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 2'd0, 8'h75, 8'h67, 8'h43};
    // reset held with DSP_REQ high: nothing may reach the RAM
    repeat (3) @(negedge CLK);
    #2;
    chk("reset_outputs", {CPU_RDY, DSP_ACK, HOST_ACK, RAM_CE, RAM_WE, RAM_A, RAM_DO, CPU_DI, DSP_DI, HOST_DI, SLOT_IDX}, '0);
    // one record per slot, starting at the first cycle after reset release
    foreach (tbl[i]) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge CLK);
        if (c == 0) begin
          RST = 1'b0;
          CPU_A = tbl[i].cpu_a;
          CPU_WE_N = tbl[i].cpu_we_n;
          DSP_REQ = tbl[i].dreq;
          HOST_REQ = tbl[i].hreq;
          HOST_WE = tbl[i].hwe;
        end
        #2;
        chk($sformatf("v%0d.c%0d slot", i, c), 32'(SLOT_IDX), 32'(tbl[i].slot));
        chk($sformatf("v%0d.c%0d ce", i, c), 32'(RAM_CE), 32'(c == 0 && tbl[i].ce));
        chk($sformatf("v%0d.c%0d we", i, c), 32'(RAM_WE), 32'(c == 0 && tbl[i].we));
        chk($sformatf("v%0d.c%0d pulses", i, c), 32'({CPU_RDY, DSP_ACK, HOST_ACK}), 32'(c == 2 ? pulse_vec(tbl[i].pulse) : 3'b000));
        if (tbl[i].ce && c < 2) chk($sformatf("v%0d.c%0d ram_a", i, c), 32'(RAM_A), 32'(tbl[i].a));
        if (tbl[i].we && c < 2) chk($sformatf("v%0d.c%0d ram_do", i, c), 32'(RAM_DO), 32'(tbl[i].dout));
        if (c == 2) chk($sformatf("v%0d di", i), 32'({CPU_DI, DSP_DI, HOST_DI}), 32'({tbl[i].cdi, tbl[i].ddi, tbl[i].hdi}));
      end
    end
    // host held for two rounds starting at slot 1: CPU starved, DSP slot still served
    HOST_REQ = 1'b1;
    DSP_REQ = 1'b1;
    nr = 0; nd = 0; nh = 0;
    repeat (24) begin
      tick;
      nr += int'(CPU_RDY);
      nd += int'(DSP_ACK);
      nh += int'(HOST_ACK);
    end
    chk("hold_rdy_count", nr, 0);
    chk("hold_host_acks", nh, 6);
    chk("hold_dsp_acks", nd, 2);
    chk("hold_host_di", 32'(HOST_DI), 32'h43);
    HOST_REQ = 1'b0;
    DSP_REQ = 1'b0;
    tc = 0;
    for (int k = 1; k <= 12 && tc == 0; k++) begin
      tick;
      if (CPU_RDY) tc = k;
    end
    chk("rdy_resume_latency", tc, 3);
    // both requests raised at slot 1 cyc 1: host in slot 2, DSP in the following slot 0
    repeat (11) tick;
    HOST_REQ = 1'b1;
    DSP_REQ = 1'b1;
    th = 0; td = 0; nh = 0;
    for (int t = 1; t <= 12; t++) begin
      tick;
      if (HOST_ACK) begin
        th = t;
        nh++;
        HOST_REQ = 1'b0;
      end
      if (DSP_ACK) begin
        td = t;
        DSP_REQ = 1'b0;
      end
    end
    chk("both_host_time", th, 4);
    chk("both_dsp_time", td, 10);
    chk("both_host_count", nh, 1);
    // reset at cyc 1 of a CPU read slot: pending pulse dropped, everything back to reset values
    RST = 1'b1;
    tick;
    chk("midslot_reset_outputs", {CPU_RDY, DSP_ACK, HOST_ACK, RAM_CE, RAM_WE, RAM_A, RAM_DO, CPU_DI, DSP_DI, HOST_DI, SLOT_IDX}, '0);
    RST = 1'b0;
    tc = 0;
    for (int k = 1; k <= 12 && tc == 0; k++) begin
      tick;
      if (RAM_CE) begin
        tc = k;
        chk("post_reset_ram_a", 32'(RAM_A), 32'h1000);
        chk("post_reset_slot", 32'(SLOT_IDX), 32'd1);
      end
    end
    chk("post_reset_first_ce", tc, 3);
    tc = 0;
    for (int k = 1; k <= 12 && tc == 0; k++) begin
      tick;
      if (CPU_RDY) tc = k;
    end
    chk("post_reset_first_rdy", tc, 2);
    chk("post_reset_cpu_di", 32'(CPU_DI), 32'h75);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
